// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit with architectural HI/LO registers.
// An operation latches its operands on Start, holds Busy for a fixed
// number of cycles, then writes HI/LO in a single edge. mthi/mtlo write
// HI or LO directly while the unit is idle.
module mult_div_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [1:0]  MnDOp,
    input  logic        MnDStart,
    input  logic        MnDWe,
    input  logic        MnDHiLo,
    input  logic        Flush,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [3:0] MULT_CNT = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_CNT  = 4'(DIV_CYCLES);

    state_t      state_r;
    logic [3:0]  cnt_r;
    logic [1:0]  op_r;
    logic [31:0] a_r;
    logic [31:0] b_r;
    logic [31:0] hi_r;
    logic [31:0] lo_r;
    logic        busy_r;

    logic [63:0] prod_s;
    logic [31:0] mag_a_s;
    logic [31:0] mag_b_s;
    logic [31:0] safe_b_s;
    logic [31:0] uquo_s;
    logic [31:0] urem_s;
    logic [31:0] res_hi_s;
    logic [31:0] res_lo_s;
    logic        res_wr_s;

    // Two's complement negation.
    function automatic logic [31:0] neg32(input logic [31:0] v);
        return ~v + 32'd1;
    endfunction

    // Magnitude of v, treating it as signed only when is_signed is set.
    function automatic logic [31:0] abs32(input logic [31:0] v, input logic is_signed);
        logic [31:0] r;
        if (is_signed && v[31]) begin
            r = neg32(v);
        end else begin
            r = v;
        end
        return r;
    endfunction

    // Result datapath: works only from the latched operands, so A/B/MnDOp
    // may change freely while the operation runs. Division is done on
    // magnitudes and the signs are fixed up afterwards; this also gives
    // 0x80000000 / -1 = 0x80000000 rem 0 without a special case.
    always_comb begin
        prod_s   = {{32{op_r[0] & a_r[31]}}, a_r} * {{32{op_r[0] & b_r[31]}}, b_r};
        mag_a_s  = abs32(a_r, op_r[0]);
        mag_b_s  = abs32(b_r, op_r[0]);
        safe_b_s = (b_r == 32'd0) ? 32'd1 : mag_b_s;
        uquo_s   = mag_a_s / safe_b_s;
        urem_s   = mag_a_s % safe_b_s;
        res_hi_s = hi_r;
        res_lo_s = lo_r;
        res_wr_s = 1'b0;
        case (op_r)
            2'b00, 2'b01: begin
                res_hi_s = prod_s[63:32];
                res_lo_s = prod_s[31:0];
                res_wr_s = 1'b1;
            end
            2'b10: begin
                res_hi_s = urem_s;
                res_lo_s = uquo_s;
                res_wr_s = (b_r != 32'd0);
            end
            2'b11: begin
                res_hi_s = a_r[31] ? neg32(urem_s) : urem_s;
                res_lo_s = (a_r[31] ^ b_r[31]) ? neg32(uquo_s) : uquo_s;
                res_wr_s = (b_r != 32'd0);
            end
            default: begin
                res_hi_s = hi_r;
                res_lo_s = lo_r;
                res_wr_s = 1'b0;
            end
        endcase
    end

    // Control FSM, operand latches and HI/LO registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            cnt_r   <= 4'd0;
            op_r    <= 2'b00;
            a_r     <= 32'd0;
            b_r     <= 32'd0;
            hi_r    <= 32'd0;
            lo_r    <= 32'd0;
            busy_r  <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (MnDStart && !Flush) begin
                        op_r    <= MnDOp;
                        a_r     <= A;
                        b_r     <= B;
                        cnt_r   <= MnDOp[1] ? DIV_CNT : MULT_CNT;
                        state_r <= RUN;
                        busy_r  <= 1'b1;
                    end else if (MnDWe && !Flush) begin
                        if (MnDHiLo) begin
                            hi_r <= A;
                        end else begin
                            lo_r <= A;
                        end
                    end
                end
                RUN: begin
                    if (cnt_r <= 4'd1) begin
                        if (res_wr_s) begin
                            hi_r <= res_hi_s;
                            lo_r <= res_lo_s;
                        end
                        cnt_r   <= 4'd0;
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                    end else begin
                        cnt_r <= cnt_r - 4'd1;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    cnt_r   <= 4'd0;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign Busy = busy_r;
    assign HI   = hi_r;
    assign LO   = lo_r;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed vectors plus randomized
// operations checked against a plain-arithmetic reference of HI/LO.
module tb_mult_div_unit;

    localparam int MULT_CYCLES = 5;
    localparam int DIV_CYCLES  = 10;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] A = 32'd0;
    logic [31:0] B = 32'd0;
    logic [1:0]  MnDOp = 2'b00;
    logic        MnDStart = 1'b0;
    logic        MnDWe = 1'b0;
    logic        MnDHiLo = 1'b0;
    logic        Flush = 1'b0;
    logic        Busy;
    logic [31:0] HI;
    logic [31:0] LO;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] hi_m = 32'd0;
    logic [31:0] lo_m = 32'd0;

    mult_div_unit #(.MULT_CYCLES(MULT_CYCLES), .DIV_CYCLES(DIV_CYCLES)) dut (
        .clk(clk), .rst_n(rst_n), .A(A), .B(B), .MnDOp(MnDOp),
        .MnDStart(MnDStart), .MnDWe(MnDWe), .MnDHiLo(MnDHiLo), .Flush(Flush),
        .Busy(Busy), .HI(HI), .LO(LO)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: HI/LO after an operation, from plain 64-bit arithmetic.
    task automatic ref_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        longint unsigned ua, ub, p;
        sa = longint'(signed'(a));
        sb = longint'(signed'(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (op)
            2'b00: begin p = ua * ub; hi_m = p[63:32]; lo_m = p[31:0]; end
            2'b01: begin q = sa * sb; hi_m = q[63:32]; lo_m = q[31:0]; end
            2'b10: if (b != 32'd0) begin lo_m = a / b; hi_m = a % b; end
            default: if (b != 32'd0) begin
                q = sa / sb; r = sa % sb;
                lo_m = q[31:0]; hi_m = r[31:0];
            end
        endcase
    endtask

    // Stimulus driver: issue a Start and follow Busy to completion,
    // reporting how long Busy stayed high and whether HI/LO moved meanwhile.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input bit scramble, input bit pulse_we, input bit hold_flush,
                          output int busy_cnt, output bit stable);
        logic [31:0] hi0, lo0;
        hi0 = HI; lo0 = LO;
        MnDOp = op; A = a; B = b; MnDStart = 1'b1;
        step();
        MnDStart = 1'b0;
        Flush = hold_flush;
        busy_cnt = 0;
        stable = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (!Busy) break;
            busy_cnt++;
            if (HI !== hi0 || LO !== lo0) stable = 1'b0;
            if (scramble) begin
                A = $urandom; B = $urandom; MnDOp = 2'($urandom_range(0, 3));
            end
            MnDWe = pulse_we && (i == 2);
            MnDHiLo = 1'($urandom_range(0, 1));
            step();
        end
        MnDWe = 1'b0;
        Flush = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        checks++;
        if (Busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) begin
            errors++;
            $display("FAIL reset: Busy=%b HI=%h LO=%h, required 0/0/0", Busy, HI, LO);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_mult();
        int n; bit st;
        logic [31:0] av [4] = '{32'hFFFFFFFE, 32'hFFFFFFFE, 32'h80000000, 32'h7FFFFFFF};
        logic [31:0] bv [4] = '{32'd3, 32'd3, 32'hFFFFFFFF, 32'h80000000};
        logic [1:0]  ov [4] = '{2'b01, 2'b00, 2'b01, 2'b00};
        for (int i = 0; i < 4; i++) begin
            run_op(ov[i], av[i], bv[i], 1'b0, 1'b0, 1'b0, n, st);
            ref_op(ov[i], av[i], bv[i]);
            checks++;
            if (n !== MULT_CYCLES || HI !== hi_m || LO !== lo_m || !st) begin
                errors++;
                $display("FAIL mult[%0d]: busy=%0d HI=%h LO=%h stable=%0d, required busy=%0d HI=%h LO=%h stable=1",
                         i, n, HI, LO, st, MULT_CYCLES, hi_m, lo_m);
            end
        end
    endtask

    task automatic test_div();
        int n; bit st;
        logic [31:0] av [4] = '{32'hFFFFFFF9, 32'd7, 32'h80000000, 32'd100};
        logic [31:0] bv [4] = '{32'd2, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFF9};
        logic [1:0]  ov [4] = '{2'b11, 2'b10, 2'b11, 2'b11};
        for (int i = 0; i < 4; i++) begin
            run_op(ov[i], av[i], bv[i], 1'b0, 1'b0, 1'b0, n, st);
            ref_op(ov[i], av[i], bv[i]);
            checks++;
            if (n !== DIV_CYCLES || HI !== hi_m || LO !== lo_m || !st) begin
                errors++;
                $display("FAIL div[%0d]: busy=%0d HI=%h LO=%h stable=%0d, required busy=%0d HI=%h LO=%h stable=1",
                         i, n, HI, LO, st, DIV_CYCLES, hi_m, lo_m);
            end
        end
    endtask

    task automatic test_mt_and_divzero();
        int n; bit st;
        MnDWe = 1'b1; MnDHiLo = 1'b1; A = 32'h11; step();
        MnDHiLo = 1'b0; A = 32'h22; step();
        MnDWe = 1'b0;
        hi_m = 32'h11; lo_m = 32'h22;
        checks++;
        if (HI !== hi_m || LO !== lo_m) begin
            errors++;
            $display("FAIL mthi_mtlo: HI=%h LO=%h, required HI=%h LO=%h", HI, LO, hi_m, lo_m);
        end
        for (int op = 2; op < 4; op++) begin
            run_op(2'(op), 32'h1234, 32'd0, 1'b0, 1'b0, 1'b0, n, st);
            checks++;
            if (n !== DIV_CYCLES || HI !== 32'h11 || LO !== 32'h22) begin
                errors++;
                $display("FAIL divzero[%0d]: busy=%0d HI=%h LO=%h, required busy=%0d HI=00000011 LO=00000022",
                         op, n, HI, LO, DIV_CYCLES);
            end
        end
        MnDWe = 1'b1; MnDHiLo = 1'b1; A = 32'hDEADBEEF; step();
        MnDWe = 1'b0;
        hi_m = 32'hDEADBEEF;
        checks++;
        if (HI !== 32'hDEADBEEF || LO !== lo_m) begin
            errors++;
            $display("FAIL mthi: HI=%h LO=%h, required HI=deadbeef LO=%h", HI, LO, lo_m);
        end
    endtask

    task automatic test_we_busy_and_start_we();
        int n; bit st;
        run_op(2'b00, 32'd6, 32'd7, 1'b0, 1'b1, 1'b0, n, st);
        ref_op(2'b00, 32'd6, 32'd7);
        checks++;
        if (n !== MULT_CYCLES || HI !== hi_m || LO !== lo_m || !st) begin
            errors++;
            $display("FAIL we_while_busy: busy=%0d HI=%h LO=%h stable=%0d, required busy=%0d HI=%h LO=%h",
                     n, HI, LO, st, MULT_CYCLES, hi_m, lo_m);
        end
        MnDWe = 1'b1; MnDHiLo = 1'b0;
        run_op(2'b01, 32'hFFFFFFFD, 32'd5, 1'b0, 1'b0, 1'b0, n, st);
        ref_op(2'b01, 32'hFFFFFFFD, 32'd5);
        checks++;
        if (n !== MULT_CYCLES || HI !== hi_m || LO !== lo_m || !st) begin
            errors++;
            $display("FAIL start_and_we: busy=%0d HI=%h LO=%h, required busy=%0d HI=%h LO=%h",
                     n, HI, LO, MULT_CYCLES, hi_m, lo_m);
        end
    endtask

    task automatic test_scramble_and_flush();
        int n; bit st;
        run_op(2'b11, 32'hFFFFFF00, 32'd9, 1'b1, 1'b0, 1'b0, n, st);
        ref_op(2'b11, 32'hFFFFFF00, 32'd9);
        checks++;
        if (n !== DIV_CYCLES || HI !== hi_m || LO !== lo_m) begin
            errors++;
            $display("FAIL latched_operands: busy=%0d HI=%h LO=%h, required busy=%0d HI=%h LO=%h",
                     n, HI, LO, DIV_CYCLES, hi_m, lo_m);
        end
        Flush = 1'b1; MnDStart = 1'b1; MnDOp = 2'b10; A = 32'd50; B = 32'd3;
        step();
        MnDStart = 1'b0; MnDWe = 1'b1; MnDHiLo = 1'b1;
        checks++;
        if (Busy !== 1'b0) begin
            errors++;
            $display("FAIL flush_start: Busy=%b, required 0", Busy);
        end
        step();
        MnDWe = 1'b0; Flush = 1'b0;
        checks++;
        if (HI !== hi_m || LO !== lo_m || Busy !== 1'b0) begin
            errors++;
            $display("FAIL flush_we: HI=%h LO=%h Busy=%b, required HI=%h LO=%h Busy=0", HI, LO, Busy, hi_m, lo_m);
        end
        run_op(2'b10, 32'd50, 32'd3, 1'b0, 1'b0, 1'b1, n, st);
        ref_op(2'b10, 32'd50, 32'd3);
        checks++;
        if (n !== DIV_CYCLES || HI !== hi_m || LO !== lo_m) begin
            errors++;
            $display("FAIL flush_in_run: busy=%0d HI=%h LO=%h, required busy=%0d HI=%h LO=%h",
                     n, HI, LO, DIV_CYCLES, hi_m, lo_m);
        end
    endtask

    task automatic test_back_to_back_random();
        int n; bit st;
        logic [1:0] op; logic [31:0] a, b;
        for (int i = 0; i < 12; i++) begin
            op = 2'($urandom_range(0, 3));
            a = $urandom;
            b = ($urandom_range(0, 4) == 0) ? 32'd0 :
                (($urandom_range(0, 1) == 1) ? 32'($urandom_range(1, 20)) : 32'($urandom));
            run_op(op, a, b, 1'b1, 1'b0, 1'b0, n, st);
            ref_op(op, a, b);
            checks++;
            if (n !== (op[1] ? DIV_CYCLES : MULT_CYCLES) || HI !== hi_m || LO !== lo_m || !st) begin
                errors++;
                $display("FAIL random[%0d] op=%0d a=%h b=%h: busy=%0d HI=%h LO=%h, required busy=%0d HI=%h LO=%h",
                         i, op, a, b, n, HI, LO, op[1] ? DIV_CYCLES : MULT_CYCLES, hi_m, lo_m);
            end
        end
    endtask

    task automatic test_async_reset();
        int n; bit st;
        MnDOp = 2'b11; A = 32'd1000; B = 32'd7; MnDStart = 1'b1;
        step();
        MnDStart = 1'b0;
        step(); step();
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (Busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) begin
            errors++;
            $display("FAIL async_reset: Busy=%b HI=%h LO=%h, required 0/0/0", Busy, HI, LO);
        end
        #1;
        rst_n = 1'b1;
        hi_m = 32'd0; lo_m = 32'd0;
        run_op(2'b00, 32'd9, 32'd11, 1'b0, 1'b0, 1'b0, n, st);
        ref_op(2'b00, 32'd9, 32'd11);
        checks++;
        if (n !== MULT_CYCLES || HI !== hi_m || LO !== lo_m) begin
            errors++;
            $display("FAIL start_after_reset: busy=%0d HI=%h LO=%h, required busy=%0d HI=%h LO=%h",
                     n, HI, LO, MULT_CYCLES, hi_m, lo_m);
        end
        for (int i = 0; i < 12; i++) step();
        checks++;
        if (Busy !== 1'b0 || HI !== hi_m || LO !== lo_m) begin
            errors++;
            $display("FAIL no_late_write: Busy=%b HI=%h LO=%h, required Busy=0 HI=%h LO=%h", Busy, HI, LO, hi_m, lo_m);
        end
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_mt_and_divzero();
        test_we_busy_and_start_we();
        test_scramble_and_flush();
        test_back_to_back_random();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 SHALL have parameter MULT_CYCLES, default 5, busy cycles for mult/multu.
REQ-002 SHALL have parameter DIV_CYCLES, default 10, busy cycles for div/divu.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port A  input  32  rs operand, EXE stage, post-forwarding.
REQ-006 SHALL have port B  input  32  rt operand, EXE stage, post-forwarding.
REQ-007 SHALL have port MnDOp  input  2  operation: 00 multu, 01 mult, 10 divu, 11 div.
REQ-008 SHALL have port MnDStart  input  1  start the operation selected by MnDOp.
REQ-009 SHALL have port MnDWe  input  1  mthi/mtlo write strobe.
REQ-010 SHALL have port MnDHiLo  input  1  write target: 1 HI, 0 LO.
REQ-011 SHALL have port Flush  input  1  EXE instruction killed; suppress its Start/We.
REQ-012 SHALL have port Busy  output  1  operation in progress.
REQ-013 SHALL have port HI  output  32  HI register, direct register output.
REQ-014 SHALL have port LO  output  32  LO register, direct register output.

Function
REQ-015 SHALL be in state IDLE or RUN, with a 4-bit down-counter CNT.
REQ-016 SHALL, in IDLE with MnDStart=1 and Flush=0 at edge k, latch A, B and MnDOp, load CNT with MULT_CYCLES or DIV_CYCLES, and enter RUN.
REQ-017 SHALL drive Busy=1 exactly when in RUN: cycles k+1 .. k+N, N=selected cycle count.
REQ-018 SHALL decrement CNT once per cycle in RUN; at the edge where CNT=1 it SHALL write the result to HI/LO and return to IDLE, so HI/LO are valid in cycle k+N+1 with Busy=0.
REQ-019 SHALL compute using only the latched operands; changes on A/B/MnDOp during RUN SHALL have no effect.
REQ-020 SHALL, for mult, form the signed 64-bit product; for multu, the unsigned product; HI=bits[63:32], LO=bits[31:0].
REQ-021 SHALL, for div, give LO=quotient truncated toward zero and HI=remainder with the dividend's sign; for divu, the unsigned quotient and remainder.
REQ-022 SHALL, for div 0x80000000 / 0xFFFFFFFF, give LO=0x80000000 and HI=0.
REQ-023 SHALL, for divisor 0 (div or divu), run the full DIV_CYCLES and leave HI and LO unchanged.
REQ-024 SHALL, in IDLE with MnDWe=1, MnDStart=0 and Flush=0, write A to HI if MnDHiLo=1, else to LO, at that edge; the other register SHALL be unchanged.
REQ-025 SHALL ignore MnDStart and MnDWe while Busy=1; the stall logic is responsible for holding such instructions.
REQ-026 SHALL, with MnDStart and MnDWe both high in IDLE, perform the Start only.
REQ-027 SHALL, with Flush=1, ignore MnDStart and MnDWe that cycle; Flush SHALL NOT abort an operation already in RUN.
REQ-028 SHALL keep HI/LO unchanged in all cycles other than those defined in REQ-018 and REQ-024.

Reset
REQ-029 SHALL, on rst_n=0 at any time, immediately force IDLE, CNT=0, Busy=0, HI=0 and LO=0, independent of clk.
REQ-030 SHALL discard any operation in RUN at reset and SHALL NOT produce its result after release.
REQ-031 SHALL accept a Start at the first rising edge after rst_n deasserts.

Verification
REQ-032 SHALL verify: mult A=0xFFFFFFFE (-2), B=3 -> Busy high 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA; multu with the same operands -> HI=0x00000002, LO=0xFFFFFFFA.
REQ-033 SHALL verify: div A=0xFFFFFFF9 (-7), B=2 -> Busy high 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF; divu 7/2 -> LO=3, HI=1.
REQ-034 SHALL verify: HI=0x11, LO=0x22, then div by B=0 -> Busy high 10 cycles, HI/LO stay 0x11/0x22; div 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
REQ-035 SHALL verify: mthi A=0xDEADBEEF -> HI=0xDEADBEEF next cycle, LO unchanged; MnDWe pulsed while Busy -> no change; Start+We together -> only Start takes effect.
REQ-036 SHALL verify: A/B changed during RUN -> result still uses the latched operands; Start with Flush=1 -> Busy stays 0.
REQ-037 SHALL verify: rst_n pulsed low mid-RUN at cycle 3 of a div -> Busy, HI and LO go to 0 asynchronously, with no late result write.
